muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Front-end controller that sequences the shared 32-bit multiplier and non-restoring divider for the execute stage.
- Accepts one mul/div/mod command at a time over a valid/ready handshake and issues a one-cycle enable to the correct unit.
- Waits for that unit's completion, then holds a tagged 32-bit result until the writeback side takes it.
- Serialises all multicycle arithmetic, so the pipeline only ever sees one handshake.

Parameters:
- DATA_WIDTH, 32, operand/result width; only 32 is supported (multiplier is fixed-size).
- TAG_WIDTH, 5, width of the destination-register tag carried with each command.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock; asynchronous, active-low
- in_valid  in  1  command present
- in_ready  out  1  sequencer can take a command
- in_op  in  3  0=MUL, 1=UDIV, 2=SDIV, 3=UMOD, 4=SMOD, 5-7 illegal
- in_a, in_b  in  DATA_WIDTH  operands (a=num/x, b=denom/y)
- in_tag  in  TAG_WIDTH  destination tag
- out_valid  out  1  result held
- out_ready  in  1  consumer takes result
- out_data  out  DATA_WIDTH  result
- out_tag  out  TAG_WIDTH  tag of result
- out_busy  out  1  state != IDLE
- mul_enable  out  1  one-cycle start to multiplier
- mul_x, mul_y  out  32  multiplier operands
- mul_can_accept_cmd, mul_data_ready  in  1  multiplier status
- mul_prod  in  32  product
- div_enable  out  1  one-cycle start to divider
- div_unsgn_or_sgn  out  1  0=unsigned, 1=signed
- div_num, div_denom  out  32  divider operands
- div_can_accept_cmd, div_data_ready  in  1  divider status
- div_quot, div_rem  in  32  divider results

Behaviour:
- Reset (async assert, sync release): state=IDLE; out_valid=0, out_data=0, out_tag=0, enables=0, operand regs=0.
- States: IDLE, ISSUE, WAIT, DONE.
- in_ready = (state==IDLE).
- IDLE:
  - On in_valid && in_ready, register op/a/b/tag.
  - Legal op -> ISSUE.
  - Illegal op -> DONE with out_data=0 (one-cycle latency, no unit touched).
- ISSUE:
  - The selected unit's enable = its can_accept_cmd, combinationally from registered state.
  - If can_accept_cmd=1 -> WAIT. Otherwise stay in ISSUE (covers a unit still busy from a pre-reset command).
  - Enable is high for exactly one cycle per command.
- WAIT:
  - Completion = selected can_accept_cmd && data_ready.
  - Both flags drop at the accept edge, so a stale data_ready is never seen.
  - On completion, capture the result (MUL->prod, *DIV->quot, *MOD->rem) into out_data, copy tag, go to DONE.
- DONE:
  - out_valid=1; out_data/out_tag stable.
  - On out_ready -> IDLE. No new command is accepted in the same cycle; a minimum one-cycle bubble is required.
- Signed/unsigned: div_unsgn_or_sgn=1 for SDIV/SMOD. Sign fix-up is done inside the divider; the sequencer does no arithmetic.
- Operand outputs are registered and stable from ISSUE through WAIT.
- Unselected unit's enable stays 0 at all times.
- Reset mid-operation: the sub-units have no reset and may still be busy. The sequencer restarts in IDLE, and the next ISSUE stalls until that unit's can_accept_cmd=1. The old result is discarded.
- Any change on in_* while not IDLE is ignored.

Optional Feature:
MULDIV_DIV_ZERO_BYPASS_EN
- Defined:
  - A div/mod with in_b==0 skips the divider: IDLE -> DONE directly.
  - UDIV/SDIV give 0xFFFF_FFFF; UMOD/SMOD give in_a.
  - div_enable is never asserted for that command.
- Undefined: the divider runs normally and its (undefined) output is passed through.

Decomposition:
- Package PkgMulDiv:
  - MulDivOp enum (3 bits).
  - State enum (2 bits).
  - Packed struct PortIn_MulDivSeq {op,a,b,tag}.
  - Packed struct PortOut_MulDivSeq {data,tag}.
  - Constant DIV_ZERO_QUOT = 32'hFFFF_FFFF.
- One sub-module, muldiv_op_decode (combinational): op -> {is_mul, is_div, is_signed, want_rem, illegal}.

Test Plan:
- MUL: a=0x0001_0003, b=0x0000_0005 -> mul_enable one cycle; out_data=0x0005_000F, out_tag echoed; in_ready low until after out_ready.
- SDIV then SMOD: a=-7 (0xFFFF_FFF9), b=2 -> div_unsgn_or_sgn=1; results 0xFFFF_FFFD and 0xFFFF_FFFF.
- UDIV: a=0xFFFF_FFFF, b=0x10 -> 0x0FFF_FFFF. Hold out_ready=0 for 10 cycles -> out_valid/out_data stay constant and no second enable is issued.
- Div by zero: a=0x1234, b=0:
  - With MULDIV_DIV_ZERO_BYPASS_EN: out_valid on the cycle after accept, UDIV=0xFFFF_FFFF, UMOD=0x1234, div_enable never high.
  - Without it: div_enable pulses once.
- Reset mid-WAIT: assert rst_n=0 during a divide, release, issue a MUL while the divider is still busy -> only mul_enable fires, correct product returned. Then a UDIV stalls in ISSUE until div_can_accept_cmd=1.
- Illegal op=6 -> out_data=0 with no unit enable; back-to-back MUL/UDIV/UMOD stream with random out_ready stalls matches the reference model in order.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// Shared types for the mul/div sequencer.
// Widths are fixed at 32-bit data, 5-bit tag.
package muldiv_sequencer_pkg;

  localparam int DW = 32;
  localparam int TW = 5;

  localparam logic [DW-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    OP_MUL  = 3'd0,
    OP_UDIV = 3'd1,
    OP_SDIV = 3'd2,
    OP_UMOD = 3'd3,
    OP_SMOD = 3'd4
  } muldiv_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [2:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [TW-1:0] tag;
  } port_in_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } port_out_t;

endpackage

// File: rtl/muldiv_op_decode.sv
// Opcode classifier for the mul/div sequencer.
// Purely combinational.
module muldiv_op_decode
  import muldiv_sequencer_pkg::*;
(
  input  logic [2:0] op,
  output logic       is_mul,
  output logic       is_div,
  output logic       is_signed,
  output logic       want_rem,
  output logic       illegal
);

  always_comb begin
    is_mul    = 1'b0;
    is_div    = 1'b0;
    is_signed = 1'b0;
    want_rem  = 1'b0;
    illegal   = 1'b0;
    unique case (1'b1)
      op == OP_MUL:  is_mul = 1'b1;
      op == OP_UDIV: is_div = 1'b1;
      op == OP_SDIV: begin
        is_div    = 1'b1;
        is_signed = 1'b1;
      end
      op == OP_UMOD: begin
        is_div   = 1'b1;
        want_rem = 1'b1;
      end
      op == OP_SMOD: begin
        is_div    = 1'b1;
        is_signed = 1'b1;
        want_rem  = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences the shared multiplier / divider behind one handshake.
// MULDIV_DIV_ZERO_BYPASS_EN: divide by zero answered without the divider.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_op,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  out_busy,
  output logic                  mul_enable,
  output logic [31:0]           mul_x,
  output logic [31:0]           mul_y,
  input  logic                  mul_can_accept_cmd,
  input  logic                  mul_data_ready,
  input  logic [31:0]           mul_prod,
  output logic                  div_enable,
  output logic                  div_unsgn_or_sgn,
  output logic [31:0]           div_num,
  output logic [31:0]           div_denom,
  input  logic                  div_can_accept_cmd,
  input  logic                  div_data_ready,
  input  logic [31:0]           div_quot,
  input  logic [31:0]           div_rem
);

  state_e    state_q, state_d;
  port_in_t  cmd_q;
  port_out_t res_q;

  logic [2:0] dec_op;
  logic       is_mul, is_div, is_signed;
  logic       want_rem, illegal;
  logic       bypass, early;
  logic       sel_accept, sel_ready, finish;
  logic [DW-1:0] early_data, unit_data;

  // In IDLE decode the incoming op, otherwise the held one
  assign dec_op = (state_q == S_IDLE) ? in_op : cmd_q.op;

  muldiv_op_decode u_dec (
    .op        (dec_op),
    .is_mul    (is_mul),
    .is_div    (is_div),
    .is_signed (is_signed),
    .want_rem  (want_rem),
    .illegal   (illegal)
  );

`ifdef MULDIV_DIV_ZERO_BYPASS_EN
  assign bypass = is_div && (in_b == '0);
`else
  assign bypass = 1'b0;
`endif

  assign early = illegal || bypass;

  assign early_data = illegal  ? '0
                    : want_rem ? in_a
                    : DIV_ZERO_QUOT;

  assign sel_accept = is_mul ? mul_can_accept_cmd
                             : div_can_accept_cmd;
  assign sel_ready  = is_mul ? mul_data_ready
                             : div_data_ready;
  assign finish     = sel_accept && sel_ready;

  assign unit_data = is_mul   ? mul_prod
                   : want_rem ? div_rem
                   : div_quot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (in_valid)
          state_d = early ? S_DONE : S_ISSUE;
      S_ISSUE:
        if (sel_accept) state_d = S_WAIT;
      S_WAIT:
        if (finish) state_d = S_DONE;
      S_DONE:
        if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready         = (state_q == S_IDLE);
    out_valid        = (state_q == S_DONE);
    out_busy         = (state_q != S_IDLE);
    mul_enable       = 1'b0;
    div_enable       = 1'b0;
    div_unsgn_or_sgn = 1'b0;
    if (state_q != S_IDLE)
      div_unsgn_or_sgn = is_signed;
    if (state_q == S_ISSUE) begin
      mul_enable = is_mul && mul_can_accept_cmd;
      div_enable = is_div && div_can_accept_cmd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q <= '0;
      res_q <= '0;
    end else begin
      if (state_q == S_IDLE && in_valid) begin
        cmd_q.op  <= in_op;
        cmd_q.a   <= in_a;
        cmd_q.b   <= in_b;
        cmd_q.tag <= in_tag;
        if (early) begin
          res_q.data <= early_data;
          res_q.tag  <= in_tag;
        end
      end
      if (state_q == S_WAIT && finish) begin
        res_q.data <= unit_data;
        res_q.tag  <= cmd_q.tag;
      end
    end
  end

  assign out_data  = res_q.data;
  assign out_tag   = res_q.tag;
  assign mul_x     = cmd_q.a;
  assign mul_y     = cmd_q.b;
  assign div_num   = cmd_q.a;
  assign div_denom = cmd_q.b;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomised bench for muldiv_sequencer with behavioural units.
// Honours MULDIV_DIV_ZERO_BYPASS_EN for expected enable counts.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        out_busy;
  logic        mul_enable;
  logic [31:0] mul_x, mul_y;
  logic        mul_can_accept_cmd = 1'b1;
  logic        mul_data_ready = 1'b0;
  logic [31:0] mul_prod = '0;
  logic        div_enable;
  logic        div_unsgn_or_sgn;
  logic [31:0] div_num, div_denom;
  logic        div_can_accept_cmd = 1'b1;
  logic        div_data_ready = 1'b0;
  logic [31:0] div_quot = '0;
  logic [31:0] div_rem = '0;

  int n_checks = 0;
  int n_errors = 0;
  int mul_en_cnt = 0;
  int div_en_cnt = 0;
  int viol = 0;
  int mul_lat = 3;
  int div_lat = 5;
  logic [2:0] cur_op = '0;

  muldiv_sequencer dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_op              (in_op),
    .in_a               (in_a),
    .in_b               (in_b),
    .in_tag             (in_tag),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_data           (out_data),
    .out_tag            (out_tag),
    .out_busy           (out_busy),
    .mul_enable         (mul_enable),
    .mul_x              (mul_x),
    .mul_y              (mul_y),
    .mul_can_accept_cmd (mul_can_accept_cmd),
    .mul_data_ready     (mul_data_ready),
    .mul_prod           (mul_prod),
    .div_enable         (div_enable),
    .div_unsgn_or_sgn   (div_unsgn_or_sgn),
    .div_num            (div_num),
    .div_denom          (div_denom),
    .div_can_accept_cmd (div_can_accept_cmd),
    .div_data_ready     (div_data_ready),
    .div_quot           (div_quot),
    .div_rem            (div_rem)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: RISC-V M-extension semantics
  function automatic logic [31:0] ref_result(input logic [2:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic ovf;
    sa = a;
    sb = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: return a * b;
      3'd1: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd2: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return sa / sb;
      end
      3'd3: return (b == 0) ? a : a % b;
      3'd4: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        return sa % sb;
      end
      default: return 32'd0;
    endcase
  endfunction

  // Behavioural multiplier: no reset, fixed latency per command
  int mul_cnt = 0;
  logic [31:0] mul_pend = '0;
  always @(posedge clk) begin
    if (mul_enable) begin
      mul_cnt <= mul_lat;
      mul_pend <= mul_x * mul_y;
      mul_can_accept_cmd <= 1'b0;
      mul_data_ready <= 1'b0;
      mul_prod <= 32'hDEAD_BEEF;
    end else if (mul_cnt > 1) begin
      mul_cnt <= mul_cnt - 1;
    end else if (mul_cnt == 1) begin
      mul_cnt <= 0;
      mul_prod <= mul_pend;
      mul_can_accept_cmd <= 1'b1;
      mul_data_ready <= 1'b1;
    end
  end

  // Behavioural divider: magnitude divide then sign fix-up
  int div_cnt = 0;
  logic [31:0] q_pend = '0, r_pend = '0;
  always @(posedge clk) begin
    logic na, nb;
    logic [31:0] ma, mb, q, r;
    if (div_enable) begin
      na = div_unsgn_or_sgn && div_num[31];
      nb = div_unsgn_or_sgn && div_denom[31];
      ma = na ? -div_num : div_num;
      mb = nb ? -div_denom : div_denom;
      if (mb == 0) begin
        q = 32'hFFFF_FFFF;
        r = div_num;
      end else begin
        q = ma / mb;
        r = ma % mb;
        if (na ^ nb) q = -q;
        if (na) r = -r;
      end
      q_pend <= q;
      r_pend <= r;
      div_cnt <= div_lat;
      div_can_accept_cmd <= 1'b0;
      div_data_ready <= 1'b0;
      div_quot <= 32'hBAD0_0001;
      div_rem <= 32'hBAD0_0002;
    end else if (div_cnt > 1) begin
      div_cnt <= div_cnt - 1;
    end else if (div_cnt == 1) begin
      div_cnt <= 0;
      div_quot <= q_pend;
      div_rem <= r_pend;
      div_can_accept_cmd <= 1'b1;
      div_data_ready <= 1'b1;
    end
  end

  // Enable protocol monitor
  logic mul_en_d = 1'b0, div_en_d = 1'b0;
  always @(posedge clk) begin
    if (mul_enable) mul_en_cnt++;
    if (div_enable) div_en_cnt++;
    if (mul_enable && div_enable) viol++;
    if (mul_enable && (!mul_can_accept_cmd || mul_en_d)) viol++;
    if (div_enable && (!div_can_accept_cmd || div_en_d)) viol++;
    if (div_enable &&
        div_unsgn_or_sgn != (cur_op == 3'd2 || cur_op == 3'd4))
      viol++;
    mul_en_d = mul_enable;
    div_en_d = div_enable;
  end

  // Entered and left on a negedge
  task automatic run_cmd(input logic [2:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [4:0] tag,
                         input int stall,
                         output int lat);
    int k, m0, d0, exp_m, exp_d;
    logic [31:0] exp;
    bit fast;
    exp = ref_result(op, a, b);
    exp_m = (op == 3'd0) ? 1 : 0;
    exp_d = (op >= 3'd1 && op <= 3'd4) ? 1 : 0;
`ifdef MULDIV_DIV_ZERO_BYPASS_EN
    if (exp_d == 1 && b == 0) exp_d = 0;
`endif
    fast = (exp_m == 0) && (exp_d == 0);
    m0 = mul_en_cnt;
    d0 = div_en_cnt;
    cur_op = op;
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    in_tag = tag;
    k = 0;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) check("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_op = 3'($urandom);
    in_a = $urandom;
    in_b = $urandom;
    in_tag = 5'($urandom);
    check("in_ready_low", 32'(in_ready), 32'd0);
    if (fast) check("fast_valid", 32'(out_valid), 32'd1);
    lat = 0;
    while (!out_valid && lat < 500) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 500) check("done_timeout", 32'd0, 32'd1);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", out_data, exp);
    end
    check("data", out_data, exp);
    check("tag", 32'(out_tag), 32'(tag));
    check("done_no_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_ready", 32'(in_ready), 32'd1);
    check("mul_en_count", 32'(mul_en_cnt - m0), 32'(exp_m));
    check("div_en_count", 32'(div_en_cnt - d0), 32'(exp_d));
  endtask

  initial begin
    int lat;
    logic [2:0] op;
    logic [31:0] a, b;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(out_busy), 32'd0);
    check("rst_mul_x", mul_x, 32'd0);
    check("rst_div_denom", div_denom, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_cmd(3'd0, 32'h0001_0003, 32'h0000_0005, 5'd7, 2, lat);
    run_cmd(3'd2, 32'hFFFF_FFF9, 32'd2, 5'd3, 0, lat);
    run_cmd(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 1, lat);
    run_cmd(3'd1, 32'hFFFF_FFFF, 32'h10, 5'd9, 10, lat);
    run_cmd(3'd1, 32'h1234, 32'd0, 5'd10, 0, lat);
    run_cmd(3'd3, 32'h1234, 32'd0, 5'd11, 0, lat);
    run_cmd(3'd6, 32'h55, 32'h66, 5'd12, 1, lat);

    // Reset while a long divide is in flight
    div_lat = 40;
    cur_op = 3'd1;
    in_valid = 1'b1;
    in_op = 3'd1;
    in_a = 32'd1000;
    in_b = 32'd3;
    in_tag = 5'd1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(out_busy), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mul_lat = 2;
    run_cmd(3'd0, 32'd1234, 32'd5678, 5'd20, 0, lat);
    run_cmd(3'd1, 32'd999, 32'd7, 5'd21, 0, lat);
    check("issue_stall", 32'(lat > 15), 32'd1);

    for (int n = 0; n < 60; n++) begin
      op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7))
                                       : 3'($urandom_range(0, 4));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
      if ($urandom_range(0, 3) == 0) a = -a;
      mul_lat = $urandom_range(1, 6);
      div_lat = $urandom_range(1, 12);
      run_cmd(op, a, b, 5'($urandom), $urandom_range(0, 3), lat);
    end

    check("enable_protocol", 32'(viol), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
